// File: rtl/riscv_ex_pkg.sv
// Shared execute/writeback definitions: default widths, result-source encodings,
// the writeback entry layout and the skid-buffer occupancy states.
package riscv_ex_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    UNIT_LOGIC = 2'b00,
    UNIT_ARITH = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_RSVD  = 2'b11
  } unit_sel_e;

  typedef struct packed {
    logic                      valid;
    logic                      wr_en;
    logic [DEF_REG_ADDR_W-1:0] addr;
    logic [DEF_XLEN-1:0]       data;
  } wb_entry_t;

  // Encoded as {main valid, skid valid} so the state bits are the valid bits.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b10,
    BUF_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/ex_wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register absorbs one overflow entry; ready depends on registered state only.
module ex_wb_skid_buf
  import riscv_ex_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  buf_state_e r_state;
  buf_state_e w_nextState;
  logic [W-1:0] r_mainData;
  logic [W-1:0] r_skidData;
  logic w_accept;
  logic w_handshake;
  logic w_loadMain;
  logic w_loadSkid;
  logic w_moveSkid;

  assign o_ready     = (r_state != BUF_FULL);
  assign o_valid     = (r_state != BUF_EMPTY);
  assign o_data      = r_mainData;
  assign w_accept    = i_valid && o_ready;
  assign w_handshake = o_valid && i_ready;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= BUF_EMPTY;
    else        r_state <= w_nextState;
  end

  // Flush wins over both the accept and the handshake; data loads are suppressed too.
  always_comb begin
    w_nextState = r_state;
    w_loadMain  = 1'b0;
    w_loadSkid  = 1'b0;
    w_moveSkid  = 1'b0;
    if (i_flush) begin
      w_nextState = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            w_loadMain  = 1'b1;
            w_nextState = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (w_accept && w_handshake) begin
            w_loadMain = 1'b1;
          end else if (w_accept) begin
            w_loadSkid  = 1'b1;
            w_nextState = BUF_FULL;
          end else if (w_handshake) begin
            w_nextState = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (w_handshake) begin
            w_moveSkid  = 1'b1;
            w_nextState = BUF_ONE;
          end
        end
        default: w_nextState = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_mainData <= '0;
      r_skidData <= '0;
    end else begin
      if (w_loadMain)      r_mainData <= i_data;
      else if (w_moveSkid) r_mainData <= r_skidData;
      if (w_loadSkid)      r_skidData <= i_data;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB stage: result select and x0 filter in front of a 2-entry skid buffer.
// Optional EX_WB_PERF_CNT_EN adds Commit_Cnt / Stall_Cnt counters.
module ex_wb_stage
  import riscv_ex_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  Flush,
  input  logic                  Valid_In,
  output logic                  Ready_In,
  input  logic [1:0]            Unit_Sel,
  input  logic [XLEN-1:0]       Logic_Result,
  input  logic [XLEN-1:0]       Arith_Result,
  input  logic [XLEN-1:0]       Shift_Result,
  input  logic [REG_ADDR_W-1:0] Rd_Addr,
  input  logic                  Reg_Write,
  output logic                  Valid_Out,
  input  logic                  Ready_Out,
  output logic [XLEN-1:0]       Rd_Wr_Data,
  output logic [REG_ADDR_W-1:0] Rd_Wr_Addr,
  output logic                  Rd_Wr_En,
  output logic                  Fwd_Valid,
  output logic [REG_ADDR_W-1:0] Fwd_Addr,
  output logic [XLEN-1:0]       Fwd_Data
`ifdef EX_WB_PERF_CNT_EN
  ,
  output logic [31:0]           Commit_Cnt,
  output logic [31:0]           Stall_Cnt
`endif
);

  localparam int W = 1 + REG_ADDR_W + XLEN;

  logic [XLEN-1:0] w_selData;
  logic            w_selWe;
  logic            w_wrEn;
  logic [W-1:0]    w_inPayload;
  logic [W-1:0]    w_outPayload;

  // Reserved select yields a zero result that is never written.
  always_comb begin
    w_selData = '0;
    w_selWe   = 1'b0;
    case (unit_sel_e'(Unit_Sel))
      UNIT_LOGIC: begin w_selData = Logic_Result; w_selWe = 1'b1; end
      UNIT_ARITH: begin w_selData = Arith_Result; w_selWe = 1'b1; end
      UNIT_SHIFT: begin w_selData = Shift_Result; w_selWe = 1'b1; end
      default:    begin w_selData = '0;           w_selWe = 1'b0; end
    endcase
  end

  assign w_wrEn      = w_selWe && Reg_Write && (Rd_Addr != '0);
  assign w_inPayload = {w_wrEn, Rd_Addr, w_selData};

  ex_wb_skid_buf #(.W(W)) u_skidBuf (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .i_flush (Flush),
    .i_valid (Valid_In),
    .o_ready (Ready_In),
    .i_data  (w_inPayload),
    .o_valid (Valid_Out),
    .i_ready (Ready_Out),
    .o_data  (w_outPayload)
  );

  assign Rd_Wr_Data = w_outPayload[XLEN-1:0];
  assign Rd_Wr_Addr = w_outPayload[XLEN +: REG_ADDR_W];
  assign Rd_Wr_En   = Valid_Out && w_outPayload[W-1];
  assign Fwd_Valid  = Valid_Out && Rd_Wr_En;
  assign Fwd_Addr   = Rd_Wr_Addr;
  assign Fwd_Data   = Rd_Wr_Data;

`ifdef EX_WB_PERF_CNT_EN
  logic [31:0] r_commitCnt;
  logic [31:0] r_stallCnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_commitCnt <= '0;
      r_stallCnt  <= '0;
    end else begin
      if (Valid_Out && Ready_Out && Rd_Wr_En) r_commitCnt <= r_commitCnt + 32'd1;
      if (Valid_Out && !Ready_Out)            r_stallCnt  <= r_stallCnt + 32'd1;
    end
  end

  assign Commit_Cnt = r_commitCnt;
  assign Stall_Cnt  = r_stallCnt;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage (default build; counter checks
// are added when EX_WB_PERF_CNT_EN is defined).
module tb_ex_wb_stage;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        Flush;
  logic        Valid_In;
  logic        Ready_In;
  logic [1:0]  Unit_Sel;
  logic [31:0] Logic_Result;
  logic [31:0] Arith_Result;
  logic [31:0] Shift_Result;
  logic [4:0]  Rd_Addr;
  logic        Reg_Write;
  logic        Valid_Out;
  logic        Ready_Out;
  logic [31:0] Rd_Wr_Data;
  logic [4:0]  Rd_Wr_Addr;
  logic        Rd_Wr_En;
  logic        Fwd_Valid;
  logic [4:0]  Fwd_Addr;
  logic [31:0] Fwd_Data;
`ifdef EX_WB_PERF_CNT_EN
  logic [31:0] Commit_Cnt;
  logic [31:0] Stall_Cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 CLK = ~CLK;

  ex_wb_stage dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .Flush        (Flush),
    .Valid_In     (Valid_In),
    .Ready_In     (Ready_In),
    .Unit_Sel     (Unit_Sel),
    .Logic_Result (Logic_Result),
    .Arith_Result (Arith_Result),
    .Shift_Result (Shift_Result),
    .Rd_Addr      (Rd_Addr),
    .Reg_Write    (Reg_Write),
    .Valid_Out    (Valid_Out),
    .Ready_Out    (Ready_Out),
    .Rd_Wr_Data   (Rd_Wr_Data),
    .Rd_Wr_Addr   (Rd_Wr_Addr),
    .Rd_Wr_En     (Rd_Wr_En),
    .Fwd_Valid    (Fwd_Valid),
    .Fwd_Addr     (Fwd_Addr),
    .Fwd_Data     (Fwd_Data)
`ifdef EX_WB_PERF_CNT_EN
    ,
    .Commit_Cnt   (Commit_Cnt),
    .Stall_Cnt    (Stall_Cnt)
`endif
  );

  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [31:0] ld, input logic [31:0] ad,
                               input logic [31:0] sd, input logic [4:0] rd,
                               input logic rw, input logic ro);
    Valid_In     = v;
    Unit_Sel     = sel;
    Logic_Result = ld;
    Arith_Result = ad;
    Shift_Result = sd;
    Rd_Addr      = rd;
    Reg_Write    = rw;
    Ready_Out    = ro;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkEntry(input string tag, input logic v, input logic [31:0] d,
                            input logic [4:0] a, input logic en);
    checkOutput({tag, ".valid"}, 64'(Valid_Out), 64'(v));
    checkOutput({tag, ".data"},  64'(Rd_Wr_Data), 64'(d));
    checkOutput({tag, ".addr"},  64'(Rd_Wr_Addr), 64'(a));
    checkOutput({tag, ".en"},    64'(Rd_Wr_En),   64'(en));
    checkOutput({tag, ".fwdv"},  64'(Fwd_Valid),  64'(v && en));
    checkOutput({tag, ".fwdd"},  64'(Fwd_Data),   64'(d));
    checkOutput({tag, ".fwda"},  64'(Fwd_Addr),   64'(a));
  endtask

  initial begin
    logic [1:0]  sel;
    logic [31:0] ld, ad, sd, expData;
    logic [4:0]  rd;

    rst_n = 1'b0;
    Flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #12;
    checkEntry("reset", 1'b0, 32'h0, 5'd0, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    checkOutput("reset.ready_in", 64'(Ready_In), 64'd1);

    // single logic op, then x0 destination, then reserved select
    applyStimulus(1'b1, 2'b00, 32'hF0F0_00FF, 32'hAAAA_AAAA, 32'h5555_5555, 5'd5, 1'b1, 1'b1);
    tick();
    checkEntry("single", 1'b1, 32'hF0F0_00FF, 5'd5, 1'b1);
    applyStimulus(1'b1, 2'b01, 32'h1111_1111, 32'h1234_5678, 32'h2222_2222, 5'd0, 1'b1, 1'b1);
    tick();
    checkEntry("x0dest", 1'b1, 32'h1234_5678, 5'd0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_0BAD, 5'd7, 1'b1, 1'b1);
    tick();
    checkEntry("reserved", 1'b1, 32'h0, 5'd7, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    checkOutput("drain.valid", 64'(Valid_Out), 64'd0);

    // backpressure: 3 back-to-back inputs against a stalled writeback
    applyStimulus(1'b1, 2'b01, 32'h0, 32'd1, 32'h0, 5'd1, 1'b1, 1'b0);
    tick();
    checkOutput("bp.ready1", 64'(Ready_In), 64'd1);
    applyStimulus(1'b1, 2'b01, 32'h0, 32'd2, 32'h0, 5'd2, 1'b1, 1'b0);
    tick();
    checkOutput("bp.ready2", 64'(Ready_In), 64'd0);
    checkEntry("bp.hold1", 1'b1, 32'd1, 5'd1, 1'b1);
    applyStimulus(1'b1, 2'b01, 32'h0, 32'd3, 32'h0, 5'd3, 1'b1, 1'b0);
    tick();
    checkOutput("bp.ready3", 64'(Ready_In), 64'd0);
    checkEntry("bp.hold2", 1'b1, 32'd1, 5'd1, 1'b1);
    Ready_Out = 1'b1;
    tick();
    checkEntry("bp.out2", 1'b1, 32'd2, 5'd2, 1'b1);
    checkOutput("bp.ready4", 64'(Ready_In), 64'd1);
    tick();
    checkEntry("bp.out3", 1'b1, 32'd3, 5'd3, 1'b1);
    Valid_In = 1'b0;
    tick();
    checkOutput("bp.empty", 64'(Valid_Out), 64'd0);

    // streaming with random select and data
    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom_range(0, 3));
      ld  = $urandom;
      ad  = $urandom;
      sd  = $urandom;
      rd  = 5'($urandom_range(1, 31));
      expData = (sel == 2'b00) ? ld : (sel == 2'b01) ? ad : (sel == 2'b10) ? sd : 32'h0;
      applyStimulus(1'b1, sel, ld, ad, sd, rd, 1'b1, 1'b1);
      tick();
      checkOutput("stream.ready", 64'(Ready_In), 64'd1);
      checkOutput("stream.valid", 64'(Valid_Out), 64'd1);
      checkOutput("stream.data", 64'(Rd_Wr_Data), 64'(expData));
      checkOutput("stream.en", 64'(Rd_Wr_En), 64'(sel != 2'b11));
    end
    Valid_In = 1'b0;
    tick();
    checkOutput("stream.drain", 64'(Valid_Out), 64'd0);

    // flush in FULL with a simultaneous input
    applyStimulus(1'b1, 2'b00, 32'h0000_000A, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b00, 32'h0000_000B, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
    tick();
    checkOutput("flush.full", 64'(Ready_In), 64'd0);
    applyStimulus(1'b1, 2'b00, 32'h0000_000C, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checkOutput("flush.valid", 64'(Valid_Out), 64'd0);
    checkOutput("flush.ready", 64'(Ready_In), 64'd1);
    checkOutput("flush.en", 64'(Rd_Wr_En), 64'd0);
    checkOutput("flush.fwdv", 64'(Fwd_Valid), 64'd0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    checkOutput("flush.gone1", 64'(Valid_Out), 64'd0);
    tick();
    checkOutput("flush.gone2", 64'(Valid_Out), 64'd0);

    // asynchronous reset while stalled in FULL
    applyStimulus(1'b1, 2'b10, 32'h0, 32'h0, 32'h0000_0E01, 5'd9, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b10, 32'h0, 32'h0, 32'h0000_0E02, 5'd10, 1'b1, 1'b0);
    tick();
    checkEntry("prereset", 1'b1, 32'h0000_0E01, 5'd9, 1'b1);
    Valid_In = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkEntry("areset", 1'b0, 32'h0, 5'd0, 1'b0);
    checkOutput("areset.ready", 64'(Ready_In), 64'd1);
`ifdef EX_WB_PERF_CNT_EN
    checkOutput("areset.commit", 64'(Commit_Cnt), 64'd0);
    checkOutput("areset.stall", 64'(Stall_Cnt), 64'd0);
`endif
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    checkOutput("postreset.valid", 64'(Valid_Out), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
